// File: rtl/rle_pkg.sv
// Shared definitions for the run-length codec: FSM encoding, mode values
// and sizing helpers.
package rle_pkg;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Legacy numeric state encodings, kept stable for existing waveform decoders.
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CHECK   = 4'd1;
  localparam logic [3:0] ST_RD_ADDR = 4'd2;
  localparam logic [3:0] ST_RD_WAIT = 4'd3;
  localparam logic [3:0] ST_RD_CAP  = 4'd4;
  localparam logic [3:0] ST_PROC    = 4'd5;
  localparam logic [3:0] ST_WR      = 4'd6;
  localparam logic [3:0] ST_FLUSH   = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    CHECK   = ST_CHECK,
    RD_ADDR = ST_RD_ADDR,
    RD_WAIT = ST_RD_WAIT,
    RD_CAP  = ST_RD_CAP,
    PROC    = ST_PROC,
    WR      = ST_WR,
    FLUSH   = ST_FLUSH,
    DONE    = ST_DONE
  } state_t;

  function automatic int unsigned pair_width(input int unsigned sym_w);
    return 2 * sym_w;
  endfunction

endpackage

// File: rtl/rle_codec_packer.sv
// Little-endian word packer: appends one SYM_W unit or one (symbol, count)
// pair per push; the word is always zero above the valid bytes.
module rle_word_packer
  import rle_pkg::*;
#(
  parameter int unsigned SYM_W = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 i_push,
  input  logic                 i_pair,
  input  logic                 i_flush,
  input  logic [2*SYM_W-1:0]   i_data,
  output logic [31:0]          o_word,
  output logic [2:0]           o_bytes,
  output logic                 o_full
);

  localparam logic [2:0] UNIT_BYTES = 3'(SYM_W / 8);

  logic [31:0] r_word;
  logic [2:0]  r_bytes;
  logic [31:0] w_ext;
  logic [31:0] w_ins;
  logic [2:0]  w_add;

  always_comb begin
    w_ext = '0;
    if (i_pair) begin
      w_ext[2*SYM_W-1:0] = i_data;
    end else begin
      w_ext[SYM_W-1:0] = i_data[SYM_W-1:0];
    end
    w_ins = w_ext << {r_bytes[1:0], 3'b000};
    w_add = i_pair ? (UNIT_BYTES + UNIT_BYTES) : UNIT_BYTES;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_word  <= '0;
      r_bytes <= '0;
    end else if (i_flush) begin
      r_word  <= '0;
      r_bytes <= '0;
    end else if (i_push && !o_full) begin
      r_word  <= r_word | w_ins;
      r_bytes <= r_bytes + w_add;
    end
  end

  assign o_word  = r_word;
  assign o_bytes = r_bytes;
  assign o_full  = (r_bytes == 3'(WORD_BYTES));

endmodule

// File: rtl/rle_codec.sv
// Run-length encoder/decoder streaming over a single-port word memory.
// Encode emits (symbol, count) pairs; decode expands them back to symbols.
module rle_codec
  import rle_pkg::*;
#(
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              mode,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              err,
  output logic              port_A_clk,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we
);

  localparam int unsigned       PW         = pair_width(SYM_W);
  localparam logic [2:0]        SYM_BYTES  = 3'(SYM_W / 8);
  localparam logic [2:0]        PAIR_BYTES = 3'(PW / 8);
  localparam logic [SYM_W-1:0]  MAXCNT     = '1;

  state_t              r_state;
  logic                r_mode;
  logic                r_mis;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [31:0]         r_units;
  logic [31:0]         r_word;
  logic [1:0]          r_pos;
  logic                r_run_act;
  logic [SYM_W-1:0]    r_run_sym;
  logic [SYM_W-1:0]    r_run_cnt;
  logic                r_dec_act;
  logic [SYM_W-1:0]    r_dec_left;
  logic                r_done;
  logic                r_err;
  logic [31:0]         r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic                r_we;

  logic [31:0]         w_units_in;
  logic [SYM_W-1:0]    w_sym;
  logic [SYM_W-1:0]    w_cnt;
  logic [SYM_W-1:0]    w_dec_left;
  logic                w_same;
  logic                w_consume;
  logic [2:0]          w_pos_nx;
  logic                w_pk_push;
  logic                w_pk_pair;
  logic                w_pk_flush;
  logic [PW-1:0]       w_pk_data;
  logic [31:0]         w_pk_word;
  logic [2:0]          w_pk_bytes;
  logic                w_pk_full;
  logic                w_unused;

  assign w_unused = ^{message_addr[31:ADDR_W], rle_addr[31:ADDR_W]};

  // Input units: symbols when encoding, whole pairs when decoding.
  always_comb begin
    if (mode == MODE_DEC) begin
      w_units_in = (SYM_W == 8) ? (message_size >> 1) : (message_size >> 2);
    end else begin
      w_units_in = (SYM_W == 8) ? message_size : (message_size >> 1);
    end
  end

  assign w_sym      = SYM_W'(r_word >> {r_pos, 3'b000});
  assign w_cnt      = SYM_W'(r_word >> ({r_pos, 3'b000} + 5'(SYM_W)));
  assign w_dec_left = r_dec_act ? r_dec_left : w_cnt;
  assign w_same     = r_run_act && (w_sym == r_run_sym) && (r_run_cnt != MAXCNT);
  assign w_pos_nx   = {1'b0, r_pos} + ((r_mode == MODE_DEC) ? PAIR_BYTES : SYM_BYTES);

  // PROC priority: drain a full packer, then consume input, then close out.
  always_comb begin
    w_pk_push  = 1'b0;
    w_pk_pair  = 1'b0;
    w_pk_flush = 1'b0;
    w_pk_data  = '0;
    w_consume  = 1'b0;
    case (r_state)
      CHECK: w_pk_flush = 1'b1;
      PROC: begin
        if (w_pk_full) begin
          w_pk_flush = 1'b1;
        end else if (r_units != '0) begin
          if (r_mode == MODE_ENC) begin
            w_consume = 1'b1;
            if (r_run_act && !w_same) begin
              w_pk_push = 1'b1;
              w_pk_pair = 1'b1;
              w_pk_data = {r_run_cnt, r_run_sym};
            end
          end else begin
            w_consume = (w_dec_left <= SYM_W'(1));
            if (w_dec_left != '0) begin
              w_pk_push = 1'b1;
              w_pk_data = {{SYM_W{1'b0}}, w_sym};
            end
          end
        end else if (r_mode == MODE_ENC && r_run_act) begin
          w_pk_push = 1'b1;
          w_pk_pair = 1'b1;
          w_pk_data = {r_run_cnt, r_run_sym};
        end else if (w_pk_bytes != '0) begin
          w_pk_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  rle_word_packer #(.SYM_W(SYM_W)) u_packer (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_pk_push),
    .i_pair  (w_pk_pair),
    .i_flush (w_pk_flush),
    .i_data  (w_pk_data),
    .o_word  (w_pk_word),
    .o_bytes (w_pk_bytes),
    .o_full  (w_pk_full)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state    <= IDLE;
      r_mode     <= MODE_ENC;
      r_mis      <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_units    <= '0;
      r_word     <= '0;
      r_pos      <= '0;
      r_run_act  <= 1'b0;
      r_run_sym  <= '0;
      r_run_cnt  <= '0;
      r_dec_act  <= 1'b0;
      r_dec_left <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mode  <= mode;
            r_src   <= message_addr[ADDR_W-1:0];
            r_dst   <= rle_addr[ADDR_W-1:0];
            r_mis   <= (message_addr[1:0] != 2'b00) || (rle_addr[1:0] != 2'b00);
            r_units <= w_units_in;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= '0;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_run_act <= 1'b0;
          r_dec_act <= 1'b0;
          if (r_mis) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_units == '0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          r_addr  <= r_src;
          r_src   <= r_src + ADDR_W'(WORD_BYTES);
          r_state <= RD_WAIT;
        end
        RD_WAIT: r_state <= RD_CAP;
        RD_CAP: begin
          r_word  <= port_A_data_out;
          r_pos   <= '0;
          r_state <= PROC;
        end
        PROC: begin
          if (w_pk_full) begin
            r_addr  <= r_dst;
            r_data  <= w_pk_word;
            r_we    <= 1'b1;
            r_dst   <= r_dst + ADDR_W'(WORD_BYTES);
            r_size  <= r_size + 32'(w_pk_bytes);
            r_state <= WR;
          end else if (r_units != '0) begin
            if (r_mode == MODE_ENC) begin
              r_run_act <= 1'b1;
              if (w_same) begin
                r_run_cnt <= r_run_cnt + SYM_W'(1);
              end else begin
                r_run_sym <= w_sym;
                r_run_cnt <= SYM_W'(1);
              end
            end else if (w_consume) begin
              r_dec_act <= 1'b0;
            end else begin
              r_dec_act  <= 1'b1;
              r_dec_left <= w_dec_left - SYM_W'(1);
            end
            // A full packer left by the last unit of a word is drained after the next read.
            if (w_consume) begin
              r_units <= r_units - 32'd1;
              r_pos   <= w_pos_nx[1:0];
              if (r_units != 32'd1 && w_pos_nx[2]) begin
                r_state <= RD_ADDR;
              end
            end
          end else if (r_mode == MODE_ENC && r_run_act) begin
            r_run_act <= 1'b0;
          end else begin
            if (w_pk_bytes != '0) begin
              r_addr <= r_dst;
              r_data <= w_pk_word;
              r_we   <= 1'b1;
              r_dst  <= r_dst + ADDR_W'(WORD_BYTES);
              r_size <= r_size + 32'(w_pk_bytes);
            end
            r_state <= FLUSH;
          end
        end
        WR: begin
          r_we    <= 1'b0;
          r_state <= PROC;
        end
        FLUSH: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rle_size       = r_size;
  assign done           = r_done;
  assign err            = r_err;
  assign port_A_clk     = clk;
  assign port_A_data_in = r_data;
  assign port_A_addr    = r_addr;
  assign port_A_we      = r_we;

endmodule

// File: tb/tb_rle_codec.sv
// Directed bench for rle_codec (SYM_W=8) with a word memory on port_A.
module tb_rle_codec;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start;
  logic        mode;
  logic [31:0] message_addr;
  logic [31:0] message_size;
  logic [31:0] rle_addr;
  logic [31:0] rle_size;
  logic        done;
  logic        err;
  logic        port_A_clk;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;
  logic [15:0] port_A_addr;
  logic        port_A_we;

  logic [31:0] mem [0:255];
  logic [31:0] r_rd;
  logic        tb_we = 1'b0;
  logic [7:0]  tb_idx = '0;
  logic [31:0] tb_wdata = '0;
  int unsigned we_cnt = 0;
  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  rle_codec #(.SYM_W(8), .ADDR_W(16)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .start           (start),
    .mode            (mode),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .rle_addr        (rle_addr),
    .rle_size        (rle_size),
    .done            (done),
    .err             (err),
    .port_A_clk      (port_A_clk),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we)
  );

  always @(posedge port_A_clk) begin
    if (tb_we) mem[tb_idx] <= tb_wdata;
    else if (port_A_we) mem[port_A_addr[9:2]] <= port_A_data_in;
    r_rd <= mem[port_A_addr[9:2]];
    if (port_A_we) we_cnt <= we_cnt + 1;
  end
  assign port_A_data_out = r_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input int idx, input logic [31:0] data);
    tb_we = 1'b1;
    tb_idx = 8'(idx);
    tb_wdata = data;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic run_op(input logic m, input logic [31:0] ma, input logic [31:0] ms,
                        input logic [31:0] ra, input int glitch_at, output int cycles);
    mode = m; message_addr = ma; message_size = ms; rle_addr = ra; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 3000) begin
      if (glitch_at > 0 && cycles == glitch_at) begin
        start = 1'b1; mode = 1'b0; message_addr = 32'h0; message_size = 32'd4;
      end else begin
        start = 1'b0; mode = m; message_addr = ma; message_size = ms;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check("done", done, 1'b1);
  endtask

  task automatic fill_scn1();
    logic [31:0] wv;
    for (int w = 0; w < 12; w++) begin
      for (int b = 0; b < 4; b++) wv[8*b +: 8] = 8'(((4*w + b) / 8 + 1) * 17);
      mem_wr(w, wv);
    end
    for (int i = 50; i < 53; i++) mem_wr(i, SENT);
  endtask

  task automatic check_scn1(input string tag);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_size"}, rle_size, 32'd12);
    check({tag, "_w0"}, mem[50], 32'h0822_0811);
    check({tag, "_w1"}, mem[51], 32'h0844_0833);
    check({tag, "_w2"}, mem[52], 32'h0866_0855);
  endtask

  initial begin
    int cyc;
    int unsigned we0;
    logic [31:0] wv;
    nreset = 1'b0; start = 1'b0; mode = 1'b0;
    message_addr = '0; message_size = '0; rle_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_size", rle_size, 32'd0);
    check("rst_we", port_A_we, 1'b0);
    check("rst_addr", 32'(port_A_addr), 32'd0);
    check("rst_din", port_A_data_in, 32'd0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // Six runs of eight bytes.
    fill_scn1();
    we0 = we_cnt;
    run_op(1'b0, 32'h0, 32'd48, 32'hC8, 0, cyc);
    check_scn1("enc");
    check("enc_writes", we_cnt - we0, 32'd3);
    check("enc_latency", 32'(cyc <= 94), 32'd1);

    // Saturated run, with a start pulse mid-run that must be ignored.
    for (int i = 128; i < 203; i++) mem_wr(i, 32'hAAAA_AAAA);
    mem_wr(224, SENT); mem_wr(225, SENT);
    run_op(1'b0, 32'h200, 32'd300, 32'h380, 40, cyc);
    check("sat_size", rle_size, 32'd4);
    check("sat_w0", mem[224], 32'h2DAA_FFAA);
    check("sat_w1_untouched", mem[225], SENT);

    // 51 distinct bytes -> 51 pairs, last word half filled.
    for (int w = 0; w < 13; w++) begin
      for (int b = 0; b < 4; b++) wv[8*b +: 8] = (4*w + b < 51) ? 8'(4*w + b + 1) : 8'h00;
      mem_wr(12 + w, wv);
    end
    for (int i = 75; i < 102; i++) mem_wr(i, SENT);
    we0 = we_cnt;
    run_op(1'b0, 32'h30, 32'd51, 32'h12C, 0, cyc);
    check("part_size", rle_size, 32'd102);
    check("part_writes", we_cnt - we0, 32'd26);
    for (int j = 0; j < 25; j++)
      check($sformatf("part_w%0d", j), mem[75 + j], {8'h01, 8'(2*j + 2), 8'h01, 8'(2*j + 1)});
    check("part_last", mem[100], 32'h0000_0133);
    check("part_after", mem[101], SENT);

    // Decode (11,4) (33,2) (AA,0).
    mem_wr(208, 32'h0233_0411); mem_wr(209, 32'h0000_00AA);
    for (int i = 216; i < 219; i++) mem_wr(i, SENT);
    run_op(1'b1, 32'h340, 32'd6, 32'h360, 0, cyc);
    check("dec_size", rle_size, 32'd6);
    check("dec_w0", mem[216], 32'h1111_1111);
    check("dec_w1", mem[217], 32'h0000_3333);
    check("dec_w2_untouched", mem[218], SENT);

    // Misaligned source, then empty message.
    we0 = we_cnt;
    run_op(1'b0, 32'h2, 32'd8, 32'h3C0, 0, cyc);
    check("mis_err", err, 1'b1);
    check("mis_size", rle_size, 32'd0);
    check("mis_writes", we_cnt - we0, 32'd0);
    run_op(1'b0, 32'h0, 32'd0, 32'h3C0, 0, cyc);
    check("empty_err", err, 1'b0);
    check("empty_size", rle_size, 32'd0);

    // Abort during processing, then rerun the first scenario.
    fill_scn1();
    mode = 1'b0; message_addr = 32'h0; message_size = 32'd48; rle_addr = 32'hC8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_done", done, 1'b0);
    check("abort_err", err, 1'b0);
    check("abort_size", rle_size, 32'd0);
    check("abort_we", port_A_we, 1'b0);
    check("abort_addr", 32'(port_A_addr), 32'd0);
    check("abort_din", port_A_data_in, 32'd0);
    nreset = 1'b1;
    we0 = we_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_write", we_cnt - we0, 32'd0);
    check("abort_idle", done, 1'b0);
    for (int i = 50; i < 53; i++) mem_wr(i, SENT);
    run_op(1'b0, 32'h0, 32'd48, 32'hC8, 0, cyc);
    check_scn1("rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
